// File: rtl/disp_pkg.sv
// Shared constants for the clock-display scan driver: digit slot order and
// active-low seven-segment glyphs in {g,f,e,d,c,b,a} order.
package disp_pkg;

    typedef enum logic [1:0] {
        DIG_HT = 2'd0,
        DIG_HU = 2'd1,
        DIG_MT = 2'd2,
        DIG_MU = 2'd3
    } dig_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Slot 0 drives an[3], slot 3 drives an[0].
    function automatic logic [3:0] anode_of(input dig_e dig);
        return ~(4'b1000 >> dig);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; an invalid digit
// renders as a dash.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       valid,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (valid) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/hour_disp_scan.sv
// Four-digit common-anode scan driver for the HH:MM display: per-frame input
// shadowing, leading-zero blanking, colon, field blinking and guard slots.
module hour_disp_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 4,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hour,
    input  logic [6:0] minute,
    input  logic [1:0] blink_en,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tc
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_e             idx_q, idx_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             blink_ph_q, blink_ph_d;

    logic [4:0]       hour_sh_q, hour_sh_d;
    logic [6:0]       minute_sh_q, minute_sh_d;
    logic [1:0]       blink_sh_q, blink_sh_d;
    logic             colon_sh_q, colon_sh_d;

    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             frame_tc_q, frame_tc_d;

    logic             slot_end;
    logic             frame_end;
    logic             capture;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blanked;
    logic             blink_field;
    logic             an_on;
    logic [6:0]       glyph;

    // Counters, frame/blink bookkeeping and the once-per-frame shadow capture.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        slot_end    = (cnt_q == CNT_LAST);
        frame_end   = slot_end && (idx_q == DIG_MU);
        capture     = (idx_q == DIG_HT) && (cnt_q == '0);

        cnt_d       = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d       = slot_end ? dig_e'(idx_q + 2'd1) : idx_q;
        frm_d       = frm_q;
        blink_ph_d  = blink_ph_q;

        if (frame_end) begin
            if (frm_q == FRM_LAST) begin
                frm_d      = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end

        hour_sh_d   = capture ? hour     : hour_sh_q;
        minute_sh_d = capture ? minute   : minute_sh_q;
        blink_sh_d  = capture ? blink_en : blink_sh_q;
        colon_sh_d  = capture ? colon_en : colon_sh_q;
    end

    // Digit select and visibility, all from the shadow copies.
    always_comb begin
        digit       = '0;
        digit_valid = 1'b1;
        blanked     = 1'b0;
        blink_field = 1'b0;

        case (idx_q)
            DIG_HT: begin
                digit       = {3'b000, hour_sh_q[4]};
                blanked     = ~hour_sh_q[4];
                blink_field = blink_sh_q[1];
            end
            DIG_HU: begin
                digit       = hour_sh_q[3:0];
                digit_valid = (hour_sh_q[3:0] <= 4'd9);
                blink_field = blink_sh_q[1];
            end
            DIG_MT: begin
                digit       = {1'b0, minute_sh_q[6:4]};
                digit_valid = (minute_sh_q[6:4] <= 3'd5);
                blink_field = blink_sh_q[0];
            end
            DIG_MU: begin
                digit       = minute_sh_q[3:0];
                digit_valid = (minute_sh_q[3:0] <= 4'd9);
                blink_field = blink_sh_q[0];
            end
            default: ;
        endcase

        an_on      = (cnt_q >= CNT_GUARD) && !blanked && !(blink_field && blink_ph_q);
        an_d       = an_on ? anode_of(idx_q) : 4'hF;
        seg_d      = an_on ? glyph : SEG_BLANK;
        dp_d       = !(an_on && (idx_q == DIG_HU) && colon_sh_q);
        frame_tc_d = frame_end;
    end

    seg7_decode u_seg7_decode (
        .bcd   (digit),
        .valid (digit_valid),
        .seg   (glyph)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= DIG_HT;
            frm_q       <= '0;
            blink_ph_q  <= 1'b0;
            hour_sh_q   <= '0;
            minute_sh_q <= '0;
            blink_sh_q  <= '0;
            colon_sh_q  <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
            frame_tc_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frm_q       <= frm_d;
            blink_ph_q  <= blink_ph_d;
            hour_sh_q   <= hour_sh_d;
            minute_sh_q <= minute_sh_d;
            blink_sh_q  <= blink_sh_d;
            colon_sh_q  <= colon_sh_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_tc_q  <= frame_tc_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign frame_tc = frame_tc_q;

endmodule

// File: tb/tb_hour_disp_scan.sv
// Directed bench for hour_disp_scan with an 8-cycle slot, 2-cycle guard and
// 2-frame blink half-period; every output is checked on every cycle of a frame.
module tb_hour_disp_scan;

    localparam int SCAN_DIV     = 8;
    localparam int GUARD        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hour;
    logic [6:0] minute;
    logic [1:0] blink_en;
    logic       colon_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hour_disp_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .GUARD        (GUARD),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hour     (hour),
        .minute   (minute),
        .blink_en (blink_en),
        .colon_en (colon_en),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .frame_tc (frame_tc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one whole frame starting with the edge that reflects slot 0,
    // cycle 0. Per-slot expectations are packed slot 0 first (MSBs); a slot
    // whose anode nibble is F is expected dark. At position chg_at the hour
    // and minute inputs are changed after that edge's checks.
    task automatic run_frame(input string nm, input logic [15:0] ean,
                             input logic [27:0] eseg, input logic [3:0] edp,
                             input int chg_at, input logic [4:0] chg_hour,
                             input logic [6:0] chg_min);
        for (int p = 0; p < FRAME_LEN; p++) begin
            int s;
            int c;
            logic [3:0] x_an;
            logic [6:0] x_seg;
            logic       x_dp;
            s = p / SCAN_DIV;
            c = p % SCAN_DIV;
            if (c < GUARD) begin
                x_an  = 4'hF;
                x_seg = 7'h7F;
                x_dp  = 1'b1;
            end else begin
                x_an  = ean[(3 - s) * 4 +: 4];
                x_seg = eseg[(3 - s) * 7 +: 7];
                x_dp  = edp[3 - s];
            end
            tick();
            check($sformatf("%s p%0d an", nm, p), 32'(an), 32'(x_an));
            check($sformatf("%s p%0d seg", nm, p), 32'(seg), 32'(x_seg));
            check($sformatf("%s p%0d dp", nm, p), 32'(dp), 32'(x_dp));
            check($sformatf("%s p%0d tc", nm, p), 32'(frame_tc), 32'(p == FRAME_LEN - 1));
            if (p == chg_at) begin
                hour   = chg_hour;
                minute = chg_min;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        hour     = 5'h12;
        minute   = 7'h35;
        blink_en = 2'b00;
        colon_en = 1'b1;

        repeat (3) tick();
        check("rst an", 32'(an), 32'hF);
        check("rst seg", 32'(seg), 32'h7F);
        check("rst dp", 32'(dp), 32'h1);
        check("rst tc", 32'(frame_tc), 32'h0);
        rst = 1'b0;

        // Frames 0-1 blink phase 0; 12:35 with colon.
        run_frame("f0", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h12}, 4'b1011, -1, 5'h12, 7'h35);
        // Inputs change during idx2; this frame must still show 12:35.
        run_frame("f1", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h12}, 4'b1011, 17, 5'h11, 7'h44);
        run_frame("f2", 16'h7BDE, {7'h79, 7'h79, 7'h19, 7'h19}, 4'b1011, -1, 5'h11, 7'h44);

        // Leading-zero hour tens.
        hour   = 5'h09;
        minute = 7'h35;
        run_frame("f3", 16'hFBDE, {7'h7F, 7'h10, 7'h30, 7'h12}, 4'b1011, -1, 5'h09, 7'h35);

        // Invalid hour units, no colon.
        hour     = 5'h0C;
        minute   = 7'h47;
        colon_en = 1'b0;
        run_frame("f4", 16'hFBDE, {7'h7F, 7'h3F, 7'h19, 7'h78}, 4'b1111, -1, 5'h0C, 7'h47);

        // Invalid minute tens and units.
        hour   = 5'h10;
        minute = 7'h6A;
        run_frame("f5", 16'h7BDE, {7'h79, 7'h40, 7'h3F, 7'h3F}, 4'b1111, -1, 5'h10, 7'h6A);

        // Hour-pair blink: frames 6-7 phase 1, 8-9 phase 0, 10 phase 1.
        hour     = 5'h12;
        minute   = 7'h35;
        colon_en = 1'b1;
        blink_en = 2'b10;
        run_frame("f6", 16'hFFDE, {7'h7F, 7'h7F, 7'h30, 7'h12}, 4'b1111, -1, 5'h12, 7'h35);
        run_frame("f7", 16'hFFDE, {7'h7F, 7'h7F, 7'h30, 7'h12}, 4'b1111, -1, 5'h12, 7'h35);
        run_frame("f8", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h12}, 4'b1011, -1, 5'h12, 7'h35);
        run_frame("f9", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h12}, 4'b1011, -1, 5'h12, 7'h35);
        run_frame("f10", 16'hFFDE, {7'h7F, 7'h7F, 7'h30, 7'h12}, 4'b1111, -1, 5'h12, 7'h35);

        // Minute-pair blink, still phase 1.
        blink_en = 2'b01;
        run_frame("f11", 16'h7BFF, {7'h79, 7'h24, 7'h7F, 7'h7F}, 4'b1011, -1, 5'h12, 7'h35);

        // Reset asserted in the middle of idx2.
        blink_en = 2'b00;
        repeat (20) tick();
        check("mid pre an", 32'(an), 32'hD);
        check("mid pre seg", 32'(seg), 32'h30);
        rst      = 1'b1;
        hour     = 5'h07;
        minute   = 7'h59;
        colon_en = 1'b0;
        blink_en = 2'b10;
        tick();
        check("mid rst an", 32'(an), 32'hF);
        check("mid rst seg", 32'(seg), 32'h7F);
        check("mid rst dp", 32'(dp), 32'h1);
        check("mid rst tc", 32'(frame_tc), 32'h0);
        tick();
        check("mid hold an", 32'(an), 32'hF);
        rst = 1'b0;

        // Fresh capture of 07:59; blink phase restarts at 0.
        run_frame("r0", 16'hFBDE, {7'h7F, 7'h78, 7'h12, 7'h10}, 4'b1111, -1, 5'h07, 7'h59);
        run_frame("r1", 16'hFBDE, {7'h7F, 7'h78, 7'h12, 7'h10}, 4'b1111, -1, 5'h07, 7'h59);
        run_frame("r2", 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h10}, 4'b1111, -1, 5'h07, 7'h59);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
